// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master that shifts one command frame per start pulse into the SPI slave/RAM wrapper
// Ports:
//   clk          system clock, shared with the slave
//   rst_n        synchronous active-low reset
//   i_start      frame request, accepted only while o_busy is low
//   i_cmd_word   frame to send, latched when a start is accepted
//   o_busy       frame in progress
//   o_done       one-cycle pulse at frame end
//   o_rd_data    word captured from MISO on a read-data frame
//   o_rd_valid   one-cycle pulse with o_done on read-data frames only
//   o_ss_n       slave select, active-low
//   o_mosi       serial data to slave, MSB first
//   i_miso       serial data from slave
module spi_master_ctrl #(
    parameter int FRAME_W  = 10,
    parameter int RD_W     = 8,
    parameter int RD_LAT   = 3,
    parameter int END_GAP  = 1,
    parameter int IDLE_GAP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [FRAME_W-1:0] i_cmd_word,
    output logic               o_busy,
    output logic               o_done,
    output logic [RD_W-1:0]    o_rd_data,
    output logic               o_rd_valid,
    output logic               o_ss_n,
    output logic               o_mosi,
    input  logic               i_miso
);
    localparam int MAX_A = FRAME_W > RD_W ? FRAME_W : RD_W;
    localparam int MAX_B = RD_LAT > END_GAP ? RD_LAT : END_GAP;
    localparam int MAX_C = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int MAX_N = MAX_C > IDLE_GAP ? MAX_C : IDLE_GAP;
    localparam int CNT_W = $clog2(MAX_N + 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(END_GAP - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(RD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IDLE_GAP > 1 ? IDLE_GAP - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_CMD, S_SHIFT, S_HOLD, S_WAIT_RD, S_READ, S_GAP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [FRAME_W-1:0] r_sh;
    logic               r_rd;
    logic [RD_W-1:0]    r_rx;
    logic [RD_W-1:0]    w_rx;
    logic               w_body_end;
    logic               w_frame_end;

    assign w_rx       = {r_rx[RD_W-2:0], i_miso};
    assign w_body_end = (r_state == S_HOLD && r_cnt == HOLD_LAST) ||
                        (r_state == S_READ && r_cnt == READ_LAST);
    // The done cycle (first IDLE cycle, SS_n high, busy low) is itself the last
    // cycle of the inter-frame gap, so a held start restarts after exactly IDLE_GAP
    // high cycles; the GAP state only exists for the extra cycles beyond that one.
    assign w_frame_end = (r_state == S_GAP && r_cnt == GAP_LAST) ||
                         (w_body_end && IDLE_GAP < 2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_rd       <= 1'b0;
            r_rx       <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_rd_data  <= '0;
            o_rd_valid <= 1'b0;
            o_ss_n     <= 1'b1;
            o_mosi     <= 1'b0;
        end else begin
            o_done     <= 1'b0;
            o_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_sh    <= i_cmd_word;
                    r_rd    <= &i_cmd_word[FRAME_W-1 -: 2];
                    o_busy  <= 1'b1;
                    o_ss_n  <= 1'b0;
                    o_mosi  <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    o_mosi  <= r_sh[FRAME_W-1];
                    r_state <= S_CMD;
                end
                S_CMD: begin
                    o_mosi  <= r_sh[FRAME_W-1];
                    r_sh    <= r_sh << 1;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: if (r_cnt == SHIFT_LAST) begin
                    o_mosi  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= r_rd ? S_WAIT_RD : S_HOLD;
                end else begin
                    o_mosi <= r_sh[FRAME_W-1];
                    r_sh   <= r_sh << 1;
                    r_cnt  <= r_cnt + 1'b1;
                end
                S_HOLD: r_cnt <= r_cnt + 1'b1;
                S_WAIT_RD: if (r_cnt == LAT_LAST) begin
                    r_cnt   <= '0;
                    r_state <= S_READ;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_READ: begin
                    r_rx  <= w_rx;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_GAP: r_cnt <= r_cnt + 1'b1;
                default: r_state <= S_IDLE;
            endcase
            if (w_body_end) begin
                o_ss_n  <= 1'b1;
                r_cnt   <= '0;
                r_state <= S_GAP;
            end
            if (w_frame_end) begin
                r_state    <= S_IDLE;
                o_busy     <= 1'b0;
                o_done     <= 1'b1;
                o_rd_valid <= r_rd;
                // When the frame ends straight out of READ the last MISO bit is not yet in r_rx.
                if (r_rd) o_rd_data <= r_state == S_READ ? w_rx : r_rx;
            end
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: scoreboard bench for spi_master_ctrl with a timed MISO slave model
module tb_spi_master_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] cmd_word = '0;
    logic       miso = 1'b1;
    logic       busy, done, rd_valid, ss_n, mosi;
    logic [7:0] rd_data;

    always #5 clk = ~clk;

    spi_master_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (start),
        .i_cmd_word (cmd_word),
        .o_busy     (busy),
        .o_done     (done),
        .o_rd_data  (rd_data),
        .o_rd_valid (rd_valid),
        .o_ss_n     (ss_n),
        .o_mosi     (mosi),
        .i_miso     (miso)
    );

    typedef struct {
        int          len;
        logic [31:0] mosi;
        logic        rd;
        logic [7:0]  data;
        int          gap;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          frames = 0;
    logic [7:0]  miso_word = '0;
    logic [7:0]  exp_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Frame on MOSI while SS_n low: 0 (START), cmd[9] (CMD), cmd[9:0], then zeros.
    task automatic expect_frame(input logic [9:0] cmd, input int gap);
        exp_t e;
        e.rd   = cmd[9:8] == 2'b11;
        e.len  = e.rd ? 23 : 13;
        e.mosi = 32'({1'b0, cmd[9], cmd}) << (e.len - 12);
        e.data = e.rd ? miso_word : exp_rd;
        e.gap  = gap;
        if (e.rd) exp_rd = miso_word;
        q.push_back(e);
    endtask

    // Slave model: returns miso_word MSB first during SS_n-low cycles 16..23.
    int mlow = 0;
    always @(negedge clk) begin
        if (!rst_n || ss_n) mlow = 0;
        else mlow++;
        miso = (mlow >= 16 && mlow <= 23) ? miso_word[3'(23 - mlow)] : 1'b1;
    end

    int          lcnt = 0;
    int          hcnt = 0;
    int          gap_seen = 0;
    logic        prev_ss = 1'b1;
    logic [31:0] mcap = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            lcnt = 0;
            hcnt = 0;
            prev_ss = 1'b1;
        end else begin
            if (!ss_n) begin
                if (prev_ss) begin
                    gap_seen = hcnt;
                    lcnt = 0;
                    mcap = '0;
                end
                lcnt++;
                mcap = {mcap[30:0], mosi};
            end else begin
                hcnt = prev_ss ? hcnt + 1 : 1;
            end
            prev_ss = ss_n;
            if (rd_valid && !done) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_without_done: got 1, expected 0");
            end
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done, expected none");
                end else begin
                    e = q.pop_front();
                    chk("ss_low_len", lcnt, e.len);
                    chk("mosi_bits", mcap, e.mosi);
                    chk("rd_valid", {31'b0, rd_valid}, {31'b0, e.rd});
                    chk("rd_data", {24'b0, rd_data}, {24'b0, e.data});
                    chk("busy_at_done", {31'b0, busy}, 32'd0);
                    if (e.gap >= 0) chk("ss_high_gap", gap_seen, e.gap);
                end
                frames++;
            end
        end
    end

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (frames < target) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frames, expected %0d", frames, target);
        end
    endtask

    task automatic send(input logic [9:0] cmd, input logic [7:0] mw);
        int t;
        t = frames + 1;
        @(negedge clk);
        miso_word = mw;
        cmd_word  = cmd;
        start     = 1'b1;
        expect_frame(cmd, -1);
        @(negedge clk);
        start    = 1'b0;
        cmd_word = ~cmd;
        chk("busy_after_start", {31'b0, busy}, 32'd1);
        chk("ss_low_after_start", {31'b0, ss_n}, 32'd0);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        cmd_word = 10'h3FF;
        @(negedge clk);
        start = 1'b0;
        wait_frames(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        repeat (3) @(negedge clk);
        chk("reset_ss_n", {31'b0, ss_n}, 32'd1);
        chk("reset_mosi", {31'b0, mosi}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_rd_data", {24'b0, rd_data}, 32'd0);
        rst_n = 1'b1;
        send(10'b00_1010_0101, 8'h00);
        send(10'b01_0011_1100, 8'h00);
        send(10'b11_0000_0000, 8'h3C);
        send(10'b10_0011_1100, 8'h00);
        send(10'b11_0000_0000, 8'hA5);
        send(10'b10_0000_0001, 8'h00);
        @(negedge clk);
        cmd_word = 10'b11_0101_0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midframe_busy", {31'b0, busy}, 32'd1);
        chk("midframe_ss_n", {31'b0, ss_n}, 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", {31'b0, ss_n}, 32'd1);
        chk("abort_mosi", {31'b0, mosi}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("abort_rd_data", {24'b0, rd_data}, 32'd0);
        rst_n = 1'b1;
        exp_rd = '0;
        send(10'b00_0000_1111, 8'h00);
        base = frames;
        @(negedge clk);
        cmd_word = 10'b00_1100_0011;
        start = 1'b1;
        expect_frame(cmd_word, -1);
        expect_frame(cmd_word, 1);
        expect_frame(cmd_word, 1);
        repeat (34) @(negedge clk);
        start = 1'b0;
        wait_frames(base + 3);
        repeat (40) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
